// File: rtl/intr_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : intr_capture
// Purpose  : Interrupt source front-end for the priority interrupt
//            controller. For each asynchronous interrupt line it:
//              - synchronizes the line;
//              - detects a rising edge or tracks the level (per source);
//              - latches edges into a pending register;
//              - presents pending & MASK to the controller.
//            The controller's service handshake clears edge-pending bits.
//            Software access is through an APB-style register port.
// Ports    : pclk/prst         - clock, asynchronous active-low reset
//            paddr/pwrite/penable/pwdata/prdata/pready/perror
//                              - register access port
//            irq_i             - raw asynchronous interrupt lines
//            intr_active_o     - pending & MASK, to the controller
//            intr_valid_i / intr_to_service_i / intr_serviced_i
//                              - service handshake from the controller
// Registers: 0 MASK, 1 EDGE_SEL, 2 PENDING (W1C, edge bits only),
//            3 RAW (RO), 4 OVERRUN (W1C), 5..7 error
// Revision : 1.0 - initial release
// ============================================================================
module intr_capture #(
    parameter int NUM_P_CTRLR = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 3
) (
    input  logic                   pclk,
    input  logic                   prst,
    input  logic [ADDR_W-1:0]      paddr,
    input  logic                   pwrite,
    input  logic                   penable,
    input  logic [NUM_P_CTRLR-1:0] pwdata,
    output logic [NUM_P_CTRLR-1:0] prdata,
    output logic                   pready,
    output logic                   perror,
    input  logic [NUM_P_CTRLR-1:0] irq_i,
    output logic [NUM_P_CTRLR-1:0] intr_active_o,
    input  logic                   intr_valid_i,
    input  logic [NUM_P_CTRLR-1:0] intr_to_service_i,
    input  logic                   intr_serviced_i
);

    // ------------------------------------------------------------------
    // Register map
    // ------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] c_ADDR_MASK     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_ADDR_EDGE_SEL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_PENDING  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_ADDR_RAW      = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_ADDR_OVERRUN  = ADDR_W'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][NUM_P_CTRLR-1:0] sync_q;
    logic [NUM_P_CTRLR-1:0]                  prev_q;

    logic [NUM_P_CTRLR-1:0] mask_q,     mask_d;
    logic [NUM_P_CTRLR-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_P_CTRLR-1:0] pending_q,  pending_d;
    logic [NUM_P_CTRLR-1:0] overrun_q,  overrun_d;

    logic                   pready_q;
    logic                   perror_q;
    logic [NUM_P_CTRLR-1:0] prdata_q;

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic [NUM_P_CTRLR-1:0] w_sync;
    logic [NUM_P_CTRLR-1:0] w_rise;
    logic                   w_access;
    logic                   w_wr;
    logic                   w_wr_mask;
    logic                   w_wr_edge_sel;
    logic                   w_wr_pending;
    logic                   w_wr_overrun;
    logic                   w_addr_bad;
    logic [NUM_P_CTRLR-1:0] w_rdata;
    logic [NUM_P_CTRLR-1:0] w_svc_hit;
    logic [NUM_P_CTRLR-1:0] w_pend_clr;
    logic [NUM_P_CTRLR-1:0] w_ovr_clr;

    // ------------------------------------------------------------------
    // Synchronizer and previous-value flop. Stage 0 samples irq_i; the
    // last stage is the synchronized value used everywhere else.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign w_sync = sync_q[SYNC_STAGES-1];
    assign w_rise = w_sync & ~prev_q;

    // ------------------------------------------------------------------
    // Access decode. An access executes on any edge where penable is high
    // and the previous edge did not complete one, so a held penable yields
    // one access every second cycle.
    // ------------------------------------------------------------------
    assign w_access      = penable & ~pready_q;
    assign w_wr          = w_access & pwrite;
    assign w_wr_mask     = w_wr & (paddr == c_ADDR_MASK);
    assign w_wr_edge_sel = w_wr & (paddr == c_ADDR_EDGE_SEL);
    assign w_wr_pending  = w_wr & (paddr == c_ADDR_PENDING);
    assign w_wr_overrun  = w_wr & (paddr == c_ADDR_OVERRUN);
    assign w_addr_bad    = (paddr > c_ADDR_OVERRUN);

    always_comb begin
        w_rdata = '0;
        case (paddr)
            c_ADDR_MASK:     w_rdata = mask_q;
            c_ADDR_EDGE_SEL: w_rdata = edge_sel_q;
            c_ADDR_PENDING:  w_rdata = pending_q;
            c_ADDR_RAW:      w_rdata = w_sync;
            c_ADDR_OVERRUN:  w_rdata = overrun_q;
            default:         w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_comb begin
        mask_d     = mask_q;
        edge_sel_d = edge_sel_q;
        if (w_wr_mask) begin
            mask_d = pwdata;
        end
        if (w_wr_edge_sel) begin
            edge_sel_d = pwdata;
        end
    end

    // Clear requests gathered as vectors; they only matter in edge mode.
    assign w_pend_clr = (w_wr_pending ? pwdata : '0) | w_svc_hit;
    assign w_ovr_clr  = w_wr_overrun ? pwdata : '0;

    // ------------------------------------------------------------------
    // Per-source pending / overrun next state.
    // A service index outside 0..NUM_P_CTRLR-1 matches no source, so it
    // is ignored without any explicit range check.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_P_CTRLR; k++) begin : g_src
        logic pend_d;
        logic ovr_d;

        assign w_svc_hit[k] = intr_serviced_i & intr_valid_i &
                              (intr_to_service_i == NUM_P_CTRLR'(k));

        always_comb begin
            pend_d = pending_q[k];
            if (!edge_sel_q[k]) begin
                // Level mode follows the synchronized line; clears are moot.
                pend_d = w_sync[k];
            end else if (w_rise[k]) begin
                // A new edge beats a coincident clear so it is never lost.
                pend_d = 1'b1;
            end else if (w_pend_clr[k]) begin
                pend_d = 1'b0;
            end

            ovr_d = overrun_q[k];
            if (edge_sel_q[k] && w_rise[k] && pending_q[k]) begin
                ovr_d = 1'b1;
            end else if (w_ovr_clr[k]) begin
                ovr_d = 1'b0;
            end
        end

        assign pending_d[k] = pend_d;
        assign overrun_d[k] = ovr_d;
    end

    // ------------------------------------------------------------------
    // Register state and the access response
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            mask_q     <= '0;
            edge_sel_q <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            pready_q   <= 1'b0;
            perror_q   <= 1'b0;
            prdata_q   <= '0;
        end else begin
            mask_q     <= mask_d;
            edge_sel_q <= edge_sel_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            pready_q   <= w_access;
            // Response data is captured only at the access edge and held.
            if (w_access) begin
                prdata_q <= w_rdata;
                perror_q <= w_addr_bad;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign prdata        = prdata_q;
    assign pready        = pready_q;
    assign perror        = perror_q;
    assign intr_active_o = pending_q & mask_q;

endmodule
`default_nettype wire

// File: doc/intr_capture.md
# intr_capture

Interrupt source front-end placed directly upstream of the priority interrupt controller (`ctlr`). It performs four jobs for each asynchronous peripheral interrupt line:
- synchronizes the line;
- detects a rising edge or tracks the level, per source;
- latches edges into a pending register and gates pending with a mask;
- drives the controller's `intr_active_i`.

It also consumes the controller's service handshake to clear edge-pending bits. Software configures it through an APB-style register port with the same protocol as the controller.

## Interface
Parameters:
- `NUM_P_CTRLR`, 16: number of interrupt sources; must match the controller.
- `SYNC_STAGES`, 2: synchronizer depth, minimum 2.
- `ADDR_W`, 3: register address width.

Ports:
- `pclk`  in  1  single clock; all state updates on its rising edge.
- `prst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `paddr`  in  ADDR_W  register address.
- `pwrite`  in  1  1 = write, 0 = read.
- `penable`  in  1  access request.
- `pwdata`  in  NUM_P_CTRLR  write data.
- `prdata`  out  NUM_P_CTRLR  read data.
- `pready`  out  1  access complete pulse.
- `perror`  out  1  bad address, qualified by `pready`.
- `irq_i`  in  NUM_P_CTRLR  raw asynchronous interrupt lines, active-high.
- `intr_active_o`  out  NUM_P_CTRLR  pending & mask; connects to the controller's `intr_active_i`.
- `intr_valid_i`  in  1  from the controller's `intr_valid_o`.
- `intr_to_service_i`  in  NUM_P_CTRLR  from the controller's `intr_to_service_o`; a binary source index, zero-extended.
- `intr_serviced_i`  in  1  service-done pulse; the same signal also feeds the controller.

## Operation
Registers (read/write width NUM_P_CTRLR):
- **Address 0, MASK** (RW): 1 = source enabled.
- **Address 1, EDGE_SEL** (RW): 1 = rising-edge mode, 0 = level mode.
- **Address 2, PENDING**:
  - Read returns the pending bits.
  - Write is write-1-to-clear, applied to edge-mode bits only.
- **Address 3, RAW** (RO): synchronized `irq_i`; writes are ignored without error.
- **Address 4, OVERRUN** (R/W1C): set when an edge arrives on a source whose pending bit is already 1.
- **Addresses 5–7**: `perror` = 1; no state change; `prdata` = 0.

Synchronizer and detection:
- Each `irq_i[k]` passes through SYNC_STAGES flops to give `sync[k]`.
- A further flop holds `prev[k]`.
- `rise[k] = sync[k] & ~prev[k]`.

Pending update per source k, every cycle:
- **Level mode:** `pending[k]` <= `sync[k]`. W1C and service clears have no effect.
- **Edge mode, set:** on `rise[k]`, `pending[k]` <= 1.
- **Edge mode, clear:** `pending[k]` <= 0 if either of these holds:
  - a W1C write with `pwdata[k]` = 1;
  - `intr_serviced_i` & `intr_valid_i` & (`intr_to_service_i` == k).
- **Set versus clear in the same cycle:** set wins, so a new edge is never lost.
- **Overrun:** if `rise[k]` and `pending[k]` are both already 1, `overrun[k]` <= 1. W1C on `overrun[k]` in the same cycle as a new overrun leaves it at 1.

Output and out-of-range handling:
- `intr_active_o` = `pending & MASK`, combinational from registers only.
- Masking does not clear pending. Unmasking a pending source raises `intr_active_o` immediately.
- Changing EDGE_SEL does not alter pending. Level-to-edge keeps the current value until it is cleared.
- A service index ≥ NUM_P_CTRLR is ignored.

APB access:
- When `penable` = 1 and `pready` = 0 at a clock edge, the access executes and `pready` <= 1.
- On the next edge, `pready` <= 0, regardless of `penable`.
- `penable` held high therefore yields a `pready` pulse every second cycle, one access per pulse.
- Write effects become visible in the cycle `pready` is high.
- `prdata` and `perror` are registered at the access edge. They hold their value until the next access.

## Timing
Reset values, asynchronous while `prst` = 0:
- All outputs are 0: `prdata`, `pready`, `perror`, `intr_active_o`.
- All internal state is 0: MASK, EDGE_SEL, PENDING, OVERRUN, the synchronizer flops and `prev`.
- All sources therefore reset to masked and level mode.
- Release of `prst` is synchronous to `pclk` at system level. A line already high at release produces a rise after the synchronizer fills; in edge mode this sets pending.
- Reset mid-access aborts the access; no register write occurs.

Latencies:
- `irq_i` rise before edge 0 → `sync` high after edge SYNC_STAGES-1 → `pending` set at edge SYNC_STAGES.
- `intr_active_o` high in the same cycle as `pending`. Default: 3 edges from the first sampling edge.
- Level-mode deassertion follows with the same latency.
- Service clear: `intr_serviced_i` sampled high at edge n → `pending` bit 0 and `intr_active_o` bit 0 after edge n. The controller sees the updated vector on its next evaluation.

## Test plan
- **Reset check.** Hold `prst` = 0 with `irq_i` = 16'hFFFF. Required: all outputs 0 and every register reads 0. Release reset with MASK = 0. Required: `intr_active_o` stays 0 while RAW reads 16'hFFFF.
- **Edge capture and service clear.**
  - Setup: MASK = 16'h0010, EDGE_SEL = 16'h0010.
  - Pulse `irq_i[4]` high for 1 cycle. Required: `intr_active_o` = 16'h0010 at edge 3; it stays high after `irq_i[4]` falls.
  - Drive `intr_valid_i` = 1, `intr_to_service_i` = 4, `intr_serviced_i` = 1 for one cycle. Required: `intr_active_o` = 0 the following cycle.
- **Level mode.** MASK = 16'h0001, EDGE_SEL = 0. Hold `irq_i[0]` high for 5 cycles. Required: `intr_active_o[0]` high from edge 3 and low 3 edges after the fall. W1C of PENDING bit 0 while the line is high has no effect.
- **Overrun and set-wins.**
  - Edge mode on source 7; give it two edges without service. Required: OVERRUN reads 16'h0080.
  - Issue a W1C of PENDING coincident with a third rise. Required: pending[7] stays 1.
- **APB protocol.** Hold `penable` = 1 with a write to address 0. Required: `pready` pattern 1,0,1,0. Access address 6. Required: `perror` = 1, `prdata` = 0, no register changes.
